// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter between fetch and data stages.
// Grants one access per cycle and steers registered read data back to its owner.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IfReq,
   input  logic [31:0] IfAddr,
   output logic        IfGnt,
   output logic        IfValid,
   output logic [31:0] IfData,
   input  logic        MemReq,
   input  logic        MemWE,
   input  logic [31:0] MemAddr,
   input  logic [31:0] MemWD,
   output logic        MemGnt,
   output logic        MemValid,
   output logic [31:0] MemRD,
   output logic        StallF,
   output logic        StallM,
   output logic [31:0] A,
   output logic [31:0] WD,
   output logic        WE,
   output logic        MemToRegM,
   input  logic [31:0] RD,
   output logic        Fault,
   output logic [31:0] FaultAddr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_RD  = 2'd1,
      MEM_RD = 2'd2,
      MEM_WR = 2'd3
   } owner_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   localparam logic [31:0] UNDEF = 32'hFFFF_FFFF;

   owner_e      owner_q, owner_d;
   logic        fault_q, fault_d;
   logic [31:0] faddr_q, faddr_d;
   logic [3:0]  starve_q, starve_d;
   logic        gnt;
   logic        a_ok;

   function automatic logic allocated(input logic [31:0] a);
      return (a <= 32'h0000_0801) ||
             ((a >= 32'h007F_FBFC) && (a <= 32'h007F_FFFC));
   endfunction

   // Grant selection: starved fetch first, then data stage, then fetch.
   always_comb begin
      IfGnt  = 1'b0;
      MemGnt = 1'b0;
      if (!RST) begin
         if ((starve_q == LIMIT) && IfReq) begin
            IfGnt = 1'b1;
         end else if (MemReq) begin
            MemGnt = 1'b1;
         end else if (IfReq) begin
            IfGnt = 1'b1;
         end
      end
   end

   // Memory drive and next-state for owner, fault and starvation tracking.
   always_comb begin
      gnt       = IfGnt | MemGnt;
      A         = IfGnt ? IfAddr : (MemGnt ? MemAddr : 32'h0);
      a_ok      = allocated(A);
      WD        = MemWD;
      WE        = MemGnt & MemWE & a_ok;
      MemToRegM = gnt & ~WE & a_ok;
      StallF    = IfReq & ~IfGnt;
      StallM    = MemReq & ~MemGnt;

      owner_d = IDLE;
      if (IfGnt) begin
         owner_d = IF_RD;
      end else if (MemGnt && MemWE) begin
         owner_d = MEM_WR;
      end else if (MemGnt) begin
         owner_d = MEM_RD;
      end

      fault_d = gnt & ~a_ok;
      faddr_d = fault_d ? A : faddr_q;

      starve_d = 4'd0;
      if (IfReq && !IfGnt) begin
         starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
      end
   end

   // State registers, cleared synchronously.
   always_ff @(posedge CLK) begin
      if (RST) begin
         owner_q  <= IDLE;
         fault_q  <= 1'b0;
         faddr_q  <= 32'h0;
         starve_q <= 4'd0;
      end else begin
         owner_q  <= owner_d;
         fault_q  <= fault_d;
         faddr_q  <= faddr_d;
         starve_q <= starve_d;
      end
   end

   // Response decode; reset masks a response still in flight.
   always_comb begin
      IfValid   = (owner_q == IF_RD) & ~RST;
      MemValid  = ((owner_q == MEM_RD) | (owner_q == MEM_WR)) & ~RST;
      Fault     = fault_q & ~RST;
      FaultAddr = faddr_q;
      IfData    = fault_q ? UNDEF : RD;
      MemRD     = fault_q ? UNDEF : RD;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a queue-based response scoreboard.
// Grants are checked in the request cycle; responses by a separate monitor.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IfReq = 1'b1;
   logic [31:0] IfAddr = 32'h0;
   logic        IfGnt, IfValid;
   logic [31:0] IfData;
   logic        MemReq = 1'b1;
   logic        MemWE = 1'b0;
   logic [31:0] MemAddr = 32'h0;
   logic [31:0] MemWD = 32'h0;
   logic        MemGnt, MemValid;
   logic [31:0] MemRD;
   logic        StallF, StallM;
   logic [31:0] A, WD;
   logic        WE, MemToRegM;
   logic [31:0] RD = 32'h0;
   logic        Fault;
   logic [31:0] FaultAddr;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .CLK(CLK), .RST(RST),
      .IfReq(IfReq), .IfAddr(IfAddr), .IfGnt(IfGnt),
      .IfValid(IfValid), .IfData(IfData),
      .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
      .MemWD(MemWD), .MemGnt(MemGnt), .MemValid(MemValid),
      .MemRD(MemRD), .StallF(StallF), .StallM(StallM),
      .A(A), .WD(WD), .WE(WE), .MemToRegM(MemToRegM),
      .RD(RD), .Fault(Fault), .FaultAddr(FaultAddr)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          cyc;
      logic        is_mem;
      logic [31:0] data;
      logic        chkd;
      logic        f;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic [31:0] mem [logic [31:0]];

   always @(posedge CLK) cyc <= cyc + 1;

   // Memory model: registered read of old contents, then write.
   always @(posedge CLK) begin
      RD <= mem.exists(A) ? mem[A] : 32'h0;
      if (WE) mem[A] = WD;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic is_mem, input logic [31:0] d,
                       input logic chkd, input logic f);
      exp_t e;
      e.cyc    = cyc + 1;
      e.is_mem = is_mem;
      e.data   = d;
      e.chkd   = chkd;
      e.f      = f;
      q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #2;
   endtask

   task automatic set(input logic ir, input logic [31:0] ia,
                      input logic mr, input logic mwe,
                      input logic [31:0] ma, input logic [31:0] mwd);
      IfReq = ir; IfAddr = ia;
      MemReq = mr; MemWE = mwe; MemAddr = ma; MemWD = mwd;
   endtask

   // Response monitor: pops an expectation whenever the DUT responds.
   always begin
      exp_t e;
      @(posedge CLK);
      #4;
      if (IfValid || MemValid || Fault) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", {29'h0, IfValid, MemValid, Fault}, 32'h0);
         end else begin
            e = q.pop_front();
            chk("resp_cycle", cyc, e.cyc);
            chk("resp_owner", {30'h0, IfValid, MemValid},
                e.is_mem ? 32'h1 : 32'h2);
            if (e.chkd)
               chk("resp_data", e.is_mem ? MemRD : IfData, e.data);
            chk("resp_fault", {31'h0, Fault}, {31'h0, e.f});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   logic [31:0] b_addr [7];
   logic [31:0] b_data [7];
   logic        b_ok   [7];

   initial begin
      b_addr = '{32'h400, 32'h401, 32'h801, 32'h7FFBFC,
                 32'h7FFFFC, 32'h802, 32'h7FFBFB};
      b_data = '{32'hB0000400, 32'hB0000401, 32'hB0000801, 32'hB07FFBFC,
                 32'hB07FFFFC, 32'hFFFFFFFF, 32'hFFFFFFFF};
      b_ok   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) mem[b_addr[i]] = b_data[i];
      mem[32'h802]    = 32'h55555555;
      mem[32'h7FFBFB] = 32'h55555555;
      mem[32'h10]     = 32'h8C010004;
      mem[32'h14]     = 32'h11110014;
      mem[32'h404]    = 32'hAAAA0404;

      // Reset with both requests high
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         #1;
         chk("rst_ifgnt", {31'h0, IfGnt}, 32'h0);
         chk("rst_memgnt", {31'h0, MemGnt}, 32'h0);
         chk("rst_valid", {30'h0, IfValid, MemValid}, 32'h0);
         chk("rst_fault", {31'h0, Fault}, 32'h0);
         chk("rst_faultaddr", FaultAddr, 32'h0);
      end

      // Isolated fetch
      next_cycle();
      RST = 1'b0;
      set(1, 32'h10, 0, 0, 0, 0);
      #1;
      chk("fetch_gnt", {31'h0, IfGnt}, 32'h1);
      chk("fetch_stallf", {31'h0, StallF}, 32'h0);
      chk("fetch_a", A, 32'h10);
      chk("fetch_rdstrobe", {31'h0, MemToRegM}, 32'h1);
      push(0, 32'h8C010004, 1, 0);

      // Conflict: MEM wins, IF follows
      next_cycle();
      set(1, 32'h14, 1, 0, 32'h404, 0);
      #1;
      chk("conf_memgnt", {31'h0, MemGnt}, 32'h1);
      chk("conf_stallf", {31'h0, StallF}, 32'h1);
      chk("conf_stallm", {31'h0, StallM}, 32'h0);
      push(1, 32'hAAAA0404, 1, 0);
      next_cycle();
      set(1, 32'h14, 0, 0, 0, 0);
      #1;
      chk("conf_ifgnt", {31'h0, IfGnt}, 32'h1);
      push(0, 32'h11110014, 1, 0);

      next_cycle();
      set(0, 0, 0, 0, 0, 0);

      // Starvation override at cycle 4
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         set(1, 32'h14, 1, 0, 32'h404, 0);
         #1;
         chk("starve_ifgnt", {31'h0, IfGnt}, {31'h0, i == 4});
         chk("starve_memgnt", {31'h0, MemGnt}, {31'h0, i != 4});
         chk("starve_stallm", {31'h0, StallM}, {31'h0, i == 4});
         if (i == 4) push(0, 32'h11110014, 1, 0);
         else        push(1, 32'hAAAA0404, 1, 0);
      end

      // Region boundaries, fetched back to back
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         set(1, b_addr[i], 0, 0, 0, 0);
         #1;
         chk("bound_rdstrobe", {31'h0, MemToRegM}, {31'h0, b_ok[i]});
         push(0, b_data[i], 1, ~b_ok[i]);
      end
      next_cycle();
      set(0, 0, 0, 0, 0, 0);
      #1;
      chk("bound_faultaddr", FaultAddr, 32'h7FFBFB);

      // Write then read the stack top
      next_cycle();
      set(0, 0, 1, 1, 32'h7FFFFC, 32'h12345678);
      #1;
      chk("wr_we", {31'h0, WE}, 32'h1);
      chk("wr_a", A, 32'h7FFFFC);
      chk("wr_rdstrobe", {31'h0, MemToRegM}, 32'h0);
      push(1, 0, 0, 0);
      next_cycle();
      set(0, 0, 1, 0, 32'h7FFFFC, 0);
      #1;
      chk("rd_we", {31'h0, WE}, 32'h0);
      push(1, 32'h12345678, 1, 0);

      // Faulting write is suppressed but completes
      next_cycle();
      set(0, 0, 1, 1, 32'h802, 32'hDEADBEEF);
      #1;
      chk("fwr_memgnt", {31'h0, MemGnt}, 32'h1);
      chk("fwr_we", {31'h0, WE}, 32'h0);
      push(1, 32'hFFFFFFFF, 1, 1);
      next_cycle();
      set(0, 0, 0, 0, 0, 0);
      #1;
      chk("fwr_faultaddr", FaultAddr, 32'h802);

      // Grant followed by reset: response dropped
      next_cycle();
      set(1, 32'h10, 0, 0, 0, 0);
      #1;
      chk("drop_ifgnt", {31'h0, IfGnt}, 32'h1);
      next_cycle();
      RST = 1'b1;
      set(0, 0, 0, 0, 0, 0);
      #1;
      chk("drop_ifvalid", {31'h0, IfValid}, 32'h0);
      next_cycle();
      #1;
      chk("drop_faultaddr", FaultAddr, 32'h0);
      next_cycle();
      RST = 1'b0;
      next_cycle();
      next_cycle();
      #3;
      chk("queue_drained", q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
